// File: rtl/comp_strg_cmd_ctrl_if.sv
// Bundle of request, storage-bus and response signals for comp_strg_cmd_ctrl.
// Handshakes: a transfer happens on a rising edge where valid && ready are both 1; valid and payload hold until then.
interface comp_strg_cmd_ctrl_if #(
    parameter int STRG_ADDRESS_WIDTH = 5,
    parameter int STRG_DATA_WIDTH    = 32
);
    logic                          req_valid;
    logic                          req_ready;
    logic [1:0]                    req_cmd;
    logic [STRG_ADDRESS_WIDTH-1:0] req_addA;
    logic [STRG_ADDRESS_WIDTH-1:0] req_addB;
    logic [STRG_ADDRESS_WIDTH-1:0] req_addC;
    logic [STRG_DATA_WIDTH-1:0]    req_data;

    logic                          en;
    logic [1:0]                    cmd;
    logic [STRG_ADDRESS_WIDTH-1:0] addA;
    logic [STRG_ADDRESS_WIDTH-1:0] addB;
    logic [STRG_ADDRESS_WIDTH-1:0] addC;
    logic [STRG_DATA_WIDTH-1:0]    dq_out;
    logic                          dq_oe;
    logic [STRG_DATA_WIDTH-1:0]    dq_in;
    logic                          valid_out;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [STRG_DATA_WIDTH-1:0]    rsp_data;
    logic                          rsp_err;
    logic                          spurious;

    modport slave (
        input  req_valid, req_cmd, req_addA, req_addB, req_addC, req_data,
        input  dq_in, valid_out, rsp_ready,
        output req_ready, en, cmd, addA, addB, addC, dq_out, dq_oe,
        output rsp_valid, rsp_data, rsp_err, spurious
    );

    modport master (
        output req_valid, req_cmd, req_addA, req_addB, req_addC, req_data,
        output dq_in, valid_out, rsp_ready,
        input  req_ready, en, cmd, addA, addB, addC, dq_out, dq_oe,
        input  rsp_valid, rsp_data, rsp_err, spurious
    );
endinterface

// File: rtl/comp_strg_cmd_ctrl.sv
// Single-outstanding command controller between a request/response port and a storage array bus.
// Sequence per command: IDLE accept -> ISSUE strobe -> WAIT for valid_out (bounded) -> RESP handshake.
module comp_strg_cmd_ctrl #(
    parameter int STRG_ADDRESS_WIDTH = 5,
    parameter int STRG_DATA_WIDTH    = 32,
    parameter int TIMEOUT            = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    comp_strg_cmd_ctrl_if.slave  bus,
    output logic [1:0]           o_dbg_state
);
    localparam int              CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [1:0]      CMD_WRITE = 2'b00;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                        r_state;
    logic [CW-1:0]                 r_cnt;
    logic                          r_req_ready;
    logic                          r_en;
    logic [1:0]                    r_cmd;
    logic [STRG_ADDRESS_WIDTH-1:0] r_addA;
    logic [STRG_ADDRESS_WIDTH-1:0] r_addB;
    logic [STRG_ADDRESS_WIDTH-1:0] r_addC;
    logic [STRG_DATA_WIDTH-1:0]    r_dq_out;
    logic                          r_dq_oe;
    logic                          r_rsp_valid;
    logic [STRG_DATA_WIDTH-1:0]    r_rsp_data;
    logic                          r_rsp_err;
    logic                          r_spurious;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_en        <= 1'b0;
            r_cmd       <= 2'b00;
            r_addA      <= '0;
            r_addB      <= '0;
            r_addC      <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_spurious  <= 1'b0;
        end else begin
            // A storage result is only meaningful while a command is waiting for it.
            if (bus.valid_out && (r_state != S_WAIT)) begin
                r_spurious <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_cmd       <= bus.req_cmd;
                        r_addA      <= bus.req_addA;
                        r_addB      <= bus.req_addB;
                        r_addC      <= bus.req_addC;
                        r_en        <= 1'b1;
                        r_dq_oe     <= (bus.req_cmd == CMD_WRITE);
                        r_dq_out    <= (bus.req_cmd == CMD_WRITE) ? bus.req_data : '0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_en     <= 1'b0;
                    r_dq_oe  <= 1'b0;
                    r_dq_out <= '0;
                    r_cnt    <= '0;
                    if (r_cmd == CMD_WRITE) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the last allowed cycle still beats the timeout.
                    if (bus.valid_out) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= bus.dq_in;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.en        = r_en;
    assign bus.cmd       = r_cmd;
    assign bus.addA      = r_addA;
    assign bus.addB      = r_addB;
    assign bus.addC      = r_addC;
    assign bus.dq_out    = r_dq_out;
    assign bus.dq_oe     = r_dq_oe;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.spurious  = r_spurious;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_comp_strg_cmd_ctrl.sv
// Randomized scoreboard bench for comp_strg_cmd_ctrl: driver, storage responder and monitor run as separate processes.
`timescale 1ns/1ps
module tb_comp_strg_cmd_ctrl;
    localparam int         AW     = 5;
    localparam int         DW     = 32;
    localparam int         TO     = 15;
    localparam logic [1:0] CMD_WR = 2'b00;
    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_AD = 2'b10;
    localparam logic [1:0] CMD_SB = 2'b11;

    // Clock / reset
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    comp_strg_cmd_ctrl_if #(.STRG_ADDRESS_WIDTH(AW), .STRG_DATA_WIDTH(DW)) bus ();

    comp_strg_cmd_ctrl #(
        .STRG_ADDRESS_WIDTH(AW),
        .STRG_DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .o_dbg_state(dbg_state)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
        logic [31:0]   cyc;
    } rsp_t;

    typedef struct packed {
        logic [1:0]    cmd;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [AW-1:0] addr_c;
        logic          oe;
        logic [DW-1:0] dout;
        logic [31:0]   cyc;
    } iss_t;

    typedef struct packed {
        logic          is_wr;
        logic [31:0]   lat;
        logic [DW-1:0] data;
    } sto_t;

    rsp_t exp_q[$];
    iss_t iss_q[$];
    sto_t sto_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int n_issued  = 0;
    int n_done    = 0;
    int hold_left = 0;
    int spur_req  = 0;
    int spur_done = 0;
    logic exp_spur = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input bit with_ready);
        check("rst_en", bus.en, 1'b0);
        check("rst_cmd_addr", {bus.cmd, bus.addA, bus.addB, bus.addC}, '0);
        check("rst_dq_oe", bus.dq_oe, 1'b0);
        check("rst_dq_out", bus.dq_out, '0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, '0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_spurious", bus.spurious, 1'b0);
        if (with_ready) check("rst_req_ready", bus.req_ready, 1'b1);
    endtask

    // Driver: random request-side noise while a command is in flight, plus response backpressure.
    task automatic drive_noise();
        bus.req_valid = (hold_left > 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.req_cmd   = 2'($urandom);
        bus.req_addA  = AW'($urandom);
        bus.req_addB  = AW'($urandom);
        bus.req_addC  = AW'($urandom);
        bus.req_data  = DW'($urandom);
        if (hold_left > 0 && bus.rsp_valid) begin
            bus.rsp_ready = 1'b0;
            hold_left--;
        end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t <= 200; t++) begin
            @(negedge clk);
            if (n_done == n_issued) break;
            if (t == 200) begin
                check("resp_wait_timeout", 64'(n_done), 64'(n_issued));
                n_issued = n_done;
                exp_q.delete();
                iss_q.delete();
                sto_q.delete();
                break;
            end
            drive_noise();
        end
    endtask

    task automatic do_txn(input logic [1:0] c, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [DW-1:0] wd, input int lat,
                          input logic [DW-1:0] rd);
        rsp_t        r;
        iss_t        i;
        sto_t        s;
        int unsigned acc;
        wait_idle();
        check("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_cmd   = c;
        bus.req_addA  = a0;
        bus.req_addB  = a1;
        bus.req_addC  = a2;
        bus.req_data  = wd;
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        acc = cyc + 1;
        i.cmd    = c;
        i.addr_a = a0;
        i.addr_b = a1;
        i.addr_c = a2;
        i.oe     = (c == CMD_WR);
        i.dout   = (c == CMD_WR) ? wd : '0;
        i.cyc    = acc;
        if (c == CMD_WR) begin
            r.data = '0; r.err = 1'b0; r.cyc = acc + 1;
        end else if (lat < TO) begin
            r.data = rd; r.err = 1'b0; r.cyc = acc + 2 + lat;
        end else begin
            r.data = '0; r.err = 1'b1; r.cyc = acc + 1 + TO;
        end
        s.is_wr = (c == CMD_WR);
        s.lat   = lat;
        s.data  = rd;
        iss_q.push_back(i);
        exp_q.push_back(r);
        sto_q.push_back(s);
        n_issued++;
    endtask

    // Storage responder: answers L cycles into WAIT, or not at all when L reaches the timeout.
    initial begin
        int            vo_cnt;
        logic [DW-1:0] vo_data;
        sto_t          s;
        vo_cnt        = -1;
        vo_data       = '0;
        bus.valid_out = 1'b0;
        bus.dq_in     = '0;
        forever begin
            @(negedge clk);
            bus.valid_out = 1'b0;
            bus.dq_in     = DW'($urandom);
            if (spur_req != spur_done) begin
                bus.valid_out = 1'b1;
                spur_done     = spur_req;
            end else if (vo_cnt == 0) begin
                bus.valid_out = 1'b1;
                bus.dq_in     = vo_data;
                vo_cnt        = -1;
            end else if (vo_cnt > 0) begin
                vo_cnt--;
            end
            if (bus.en && !rst && sto_q.size() > 0) begin
                s = sto_q.pop_front();
                if (!s.is_wr && s.lat < TO) begin
                    vo_cnt  = int'(s.lat);
                    vo_data = s.data;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        iss_t          e;
        logic [1:0]    last_cmd;
        logic [AW-1:0] last_a, last_b, last_c;
        bit            rsp_started;
        last_cmd = '0; last_a = '0; last_b = '0; last_c = '0;
        rsp_started = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                last_cmd = '0; last_a = '0; last_b = '0; last_c = '0;
                rsp_started = 1'b0;
            end else begin
                if (bus.en) begin
                    if (iss_q.size() == 0) begin
                        check("en_unexpected", bus.en, 1'b0);
                    end else begin
                        e = iss_q.pop_front();
                        check("iss_cmd", bus.cmd, e.cmd);
                        check("iss_addr", {bus.addA, bus.addB, bus.addC}, {e.addr_a, e.addr_b, e.addr_c});
                        check("iss_dq_oe", bus.dq_oe, e.oe);
                        check("iss_dq_out", bus.dq_out, e.dout);
                        check("iss_cycle", 64'(cyc), 64'(e.cyc));
                        check("iss_req_ready", bus.req_ready, 1'b0);
                        last_cmd = e.cmd; last_a = e.addr_a; last_b = e.addr_b; last_c = e.addr_c;
                    end
                end else begin
                    check("idle_dq_oe", bus.dq_oe, 1'b0);
                    check("idle_dq_out", bus.dq_out, '0);
                    check("hold_cmd_addr", {bus.cmd, bus.addA, bus.addB, bus.addC},
                          {last_cmd, last_a, last_b, last_c});
                end
                if (!exp_spur) check("spurious_low", bus.spurious, 1'b0);
                if (bus.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", bus.rsp_valid, 1'b0);
                    end else begin
                        check("rsp_data", bus.rsp_data, exp_q[0].data);
                        check("rsp_err", bus.rsp_err, exp_q[0].err);
                        check("rsp_req_ready", bus.req_ready, 1'b0);
                        if (!rsp_started) begin
                            check("rsp_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                            rsp_started = 1'b1;
                        end
                        if (bus.rsp_ready) begin
                            void'(exp_q.pop_front());
                            rsp_started = 1'b0;
                            n_done++;
                        end
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        check("watchdog_done", 64'(n_done), 64'(n_issued + 1000));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Main sequence
    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_cmd   = '0;
        bus.req_addA  = '0;
        bus.req_addB  = '0;
        bus.req_addC  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals(1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals(1'b1);

        do_txn(CMD_WR, 5'd0, 5'd0, 5'd3, 32'hDEADBEEF, 0, '0);
        do_txn(CMD_RD, 5'd3, 5'd0, 5'd0, '0, 0, 32'hDEADBEEF);
        do_txn(CMD_AD, 5'd1, 5'd2, 5'd4, '0, TO + 3, 32'h12345678);
        do_txn(CMD_AD, 5'd1, 5'd2, 5'd4, '0, TO - 1, 32'hCAFEF00D);
        do_txn(CMD_SB, 5'd7, 5'd8, 5'd9, '0, TO, 32'h0BADF00D);
        do_txn(CMD_SB, 5'd31, 5'd30, 5'd29, '0, 1, 32'hFFFFFFFF);

        wait_idle();
        hold_left = 5;
        do_txn(CMD_RD, 5'd2, 5'd0, 5'd0, '0, 2, 32'hA5A5A5A5);
        wait_idle();
        hold_left = 5;
        do_txn(CMD_WR, 5'd0, 5'd0, 5'd17, 32'h5A5A5A5A, 0, '0);

        for (int k = 0; k < 40; k++) begin
            do_txn(2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom), AW'($urandom),
                   DW'($urandom), int'($urandom_range(0, TO + 2)), DW'($urandom));
        end

        // Reset pulse while a READ is waiting: the command is dropped silently.
        do_txn(CMD_RD, 5'd3, 5'd0, 5'd0, '0, TO + 5, 32'h11111111);
        repeat (4) begin
            @(negedge clk);
            drive_noise();
        end
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        exp_q.delete();
        iss_q.delete();
        sto_q.delete();
        n_issued = n_done;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals(1'b1);
        repeat (5) @(negedge clk);

        // valid_out while idle sets the sticky flag and produces no response.
        exp_spur = 1'b1;
        spur_req++;
        repeat (4) @(negedge clk);
        check("spurious_set", bus.spurious, 1'b1);
        check("spurious_no_rsp", bus.rsp_valid, 1'b0);
        do_txn(CMD_RD, 5'd9, 5'd0, 5'd0, '0, 3, 32'h00C0FFEE);
        wait_idle();
        bus.req_valid = 1'b0;
        check("spurious_sticky", bus.spurious, 1'b1);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
